// File: rtl/multi_channel_counter.sv
// multi_channel_counter: N independent up/down counters with clear, load,
// wrap/saturate, terminal-count pulse, sticky overflow and a hi/lo bit tap.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   async active-low reset
//   clr       per-channel sync clear (highest priority)
//   load      per-channel sync load of load_val[i*CNT_W +: CNT_W]
//   en        per-channel count enable
//   dir       per-channel direction, 1 = up, 0 = down
//   cnt_tap   per-channel {cnt[MSBs], cnt[LSBs]}, T = HI_TAP+LO_TAP bits
//   tc        registered terminal-count pulse
//   ovf       sticky overflow/underflow flag
module multi_channel_counter #(
  parameter int N_CH     = 5,
  parameter int CNT_W    = 121,
  parameter int LO_TAP   = 8,
  parameter int HI_TAP   = 6,
  parameter int SATURATE = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_CH-1:0]                  clr,
  input  logic [N_CH-1:0]                  load,
  input  logic [N_CH*CNT_W-1:0]            load_val,
  input  logic [N_CH-1:0]                  en,
  input  logic [N_CH-1:0]                  dir,
  output logic [N_CH*(HI_TAP+LO_TAP)-1:0]  cnt_tap,
  output logic [N_CH-1:0]                  tc,
  output logic [N_CH-1:0]                  ovf
);

  localparam int T = HI_TAP + LO_TAP;
  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] val;
    logic             tc_q;
    logic             ovf_q;
    logic             bnd;

    assign val = load_val[i*CNT_W +: CNT_W];

    // Full-width add/sub; modulo arithmetic gives the wrap values.
    assign step = dir[i] ? cnt_q + ONE
                         : cnt_q - ONE;

    assign bnd = dir[i] ? (&cnt_q) : ~(|cnt_q);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        tc_q  <= 1'b0;
        ovf_q <= 1'b0;
      end else if (clr[i]) begin
        cnt_q <= '0;
        tc_q  <= 1'b0;
        ovf_q <= 1'b0;
      end else if (load[i]) begin
        cnt_q <= val;
        tc_q  <= 1'b0;
      end else if (en[i]) begin
        if (bnd) begin
          if (SATURATE == 0) cnt_q <= step;
          tc_q  <= 1'b1;
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= step;
          tc_q  <= 1'b0;
        end
      end else begin
        tc_q <= 1'b0;
      end
    end

    assign cnt_tap[i*T +: T] =
      {cnt_q[CNT_W-1 -: HI_TAP], cnt_q[LO_TAP-1:0]};
    assign tc[i]  = tc_q;
    assign ovf[i] = ovf_q;
  end

endmodule

// File: tb/tb_multi_channel_counter.sv
// tb_multi_channel_counter: directed checks of wrap, saturate and
// default-width instances against hand-computed values.
module tb_multi_channel_counter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [2:0]   a_clr, a_load, a_en, a_dir;
  logic [23:0]  a_lv;
  logic [14:0]  a_tap;
  logic [2:0]   a_tc, a_ovf;

  logic [2:0]   s_clr, s_load, s_en, s_dir;
  logic [23:0]  s_lv;
  logic [14:0]  s_tap;
  logic [2:0]   s_tc, s_ovf;

  logic [4:0]   d_clr, d_load, d_en, d_dir;
  logic [604:0] d_lv;
  logic [69:0]  d_tap;
  logic [4:0]   d_tc, d_ovf;

  multi_channel_counter #(
    .N_CH(3), .CNT_W(8), .LO_TAP(3),
    .HI_TAP(2), .SATURATE(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .clr(a_clr), .load(a_load),
    .load_val(a_lv), .en(a_en),
    .dir(a_dir), .cnt_tap(a_tap),
    .tc(a_tc), .ovf(a_ovf)
  );

  multi_channel_counter #(
    .N_CH(3), .CNT_W(8), .LO_TAP(3),
    .HI_TAP(2), .SATURATE(1)
  ) dut_s (
    .clk(clk), .reset_n(reset_n),
    .clr(s_clr), .load(s_load),
    .load_val(s_lv), .en(s_en),
    .dir(s_dir), .cnt_tap(s_tap),
    .tc(s_tc), .ovf(s_ovf)
  );

  multi_channel_counter dut_d (
    .clk(clk), .reset_n(reset_n),
    .clr(d_clr), .load(d_load),
    .load_val(d_lv), .en(d_en),
    .dir(d_dir), .cnt_tap(d_tap),
    .tc(d_tc), .ovf(d_ovf)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [4:0] tap8(
    input logic [7:0] v);
    return {v[7:6], v[2:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_clr = '0; a_load = '0; a_en = '0;
    a_dir = '0; a_lv = '0;
    s_clr = '0; s_load = '0; s_en = '0;
    s_dir = '0; s_lv = '0;
    d_clr = '0; d_load = '0; d_en = '0;
    d_dir = '0; d_lv = '0;
    #12;
    chk("rst_a_tap", a_tap, '0);
    chk("rst_a_tc", a_tc, '0);
    chk("rst_a_ovf", a_ovf, '0);
    chk("rst_d_tap", d_tap, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ch0 counts up 10
    a_en[0] = 1'b1; a_dir[0] = 1'b1;
    repeat (10) step();
    chk("cnt10_tap0", a_tap[4:0], tap8(8'd10));
    chk("cnt10_tap12", a_tap[14:5], '0);
    chk("cnt10_tc", a_tc, '0);
    chk("cnt10_ovf", a_ovf, '0);
    a_en[0] = 1'b0;

    // ch1 wrap up
    a_lv[15:8] = 8'hFE; a_load[1] = 1'b1;
    step();
    a_load[1] = 1'b0;
    chk("ld_fe", a_tap[9:5], tap8(8'hFE));
    a_en[1] = 1'b1; a_dir[1] = 1'b1;
    step();
    chk("up_ff", a_tap[9:5], tap8(8'hFF));
    chk("up_ff_tc", a_tc[1], 1'b0);
    step();
    chk("wrap_tap", a_tap[9:5], tap8(8'h00));
    chk("wrap_tc", a_tc[1], 1'b1);
    chk("wrap_ovf", a_ovf[1], 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_tc", a_tc[1], 1'b0);
    end
    chk("post_tap", a_tap[9:5], tap8(8'd5));
    chk("post_ovf", a_ovf[1], 1'b1);
    a_en[1] = 1'b0;

    // ch0 underflow wrap, then priority
    a_lv[7:0] = 8'h00; a_load[0] = 1'b1;
    step();
    a_load[0] = 1'b0;
    a_en[0] = 1'b1; a_dir[0] = 1'b0;
    step();
    chk("dn_wrap", a_tap[4:0], tap8(8'hFF));
    chk("dn_tc", a_tc[0], 1'b1);
    chk("dn_ovf", a_ovf[0], 1'b1);
    a_clr[0] = 1'b1; a_load[0] = 1'b1;
    a_lv[7:0] = 8'h55;
    step();
    chk("pri_tap", a_tap[4:0], tap8(8'h00));
    chk("pri_ovf", a_ovf[0], 1'b0);
    chk("pri_tc", a_tc[0], 1'b0);
    a_clr[0] = 1'b0;
    step();
    chk("ld55", a_tap[4:0], tap8(8'h55));
    a_load[0] = 1'b0; a_en[0] = 1'b0;
    a_lv[15:8] = 8'h81; a_load[1] = 1'b1;
    step();
    a_load[1] = 1'b0;
    chk("ld81", a_tap[9:5], tap8(8'h81));
    chk("ld_keep_ovf", a_ovf[1], 1'b1);

    // saturate: ch2 down at 0
    s_en[2] = 1'b1; s_dir[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("sat_dn_tap", s_tap[14:10], '0);
      chk("sat_dn_tc", s_tc[2], 1'b1);
      chk("sat_dn_ovf", s_ovf[2], 1'b1);
    end
    s_dir[2] = 1'b1;
    step();
    chk("sat_up1", s_tap[14:10], tap8(8'd1));
    chk("sat_up1_tc", s_tc[2], 1'b0);
    s_en[2] = 1'b0;
    s_lv[7:0] = 8'hFF; s_load[0] = 1'b1;
    step();
    s_load[0] = 1'b0;
    s_en[0] = 1'b1; s_dir[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("sat_hi_tap", s_tap[4:0], tap8(8'hFF));
      chk("sat_hi_tc", s_tc[0], 1'b1);
    end
    s_en[0] = 1'b0;
    step();
    chk("sat_hi_tc0", s_tc[0], 1'b0);

    // default params, ch4 wide wrap
    d_lv[4*121 +: 121] = {121{1'b1}} - 121'd1;
    d_load[4] = 1'b1;
    step();
    d_load[4] = 1'b0;
    chk("w_ld", d_tap[56 +: 14], {6'h3F, 8'hFE});
    d_en[4] = 1'b1; d_dir[4] = 1'b1;
    step();
    chk("w_max", d_tap[56 +: 14], {6'h3F, 8'hFF});
    chk("w_max_tc", d_tc[4], 1'b0);
    step();
    chk("w_wrap", d_tap[56 +: 14], '0);
    chk("w_wrap_tc", d_tc[4], 1'b1);
    chk("w_wrap_ovf", d_ovf[4], 1'b1);
    d_en[4] = 1'b0;
    step();
    chk("w_tc_off", d_tc[4], 1'b0);
    chk("w_others", d_tap[55:0], '0);

    // async reset mid-count
    a_en = 3'b111; a_dir = 3'b111;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_tap", a_tap, '0);
    chk("ar_tc", a_tc, '0);
    chk("ar_ovf", a_ovf, '0);
    chk("ar_s_ovf", s_ovf, '0);
    step();
    chk("ar_hold", a_tap, '0);
    reset_n = 1'b1;
    step();
    chk("ar_resume", a_tap,
        {tap8(8'd1), tap8(8'd1), tap8(8'd1)});

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
